inst_prefetch_q: RTL and testbench
==================================

# inst_prefetch_q

Instruction prefetch queue between the shared single-port instruction/data memory and the IF/ID pipeline register of the RV32 pipeline. It issues sequential fetch requests whenever the memory port is not claimed by a data access, buffers returned words with their PC, and presents them to IF/ID with a valid/ready handshake. A taken branch or jump from EX/MEM flushes the queue, discards any in-flight response and restarts fetching at the target.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect  in  1  taken branch/jump from EX/MEM; flush and restart
- redirect_pc  in  32  restart address; bits [1:0] ignored (forced 0)
- halt  in  1  ebreak/ecall; stop issuing new requests while high
- mem_req  out  1  fetch request
- mem_addr  out  32  fetch address, word aligned
- mem_gnt  in  1  port free for fetch this cycle (no data access)
- mem_rvalid  in  1  read data valid; exactly one cycle after an accepted request
- mem_rdata  in  32  instruction word
- out_valid  out  1  head entry valid
- out_inst  out  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0
- out_pc  out  32  PC of head instruction; 0 when out_valid=0
- out_ready  in  1  IF/ID accepts head this cycle

## Operation
- Reset values: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_inst=NOP, out_pc=0; fetch_pc=RESET_PC, count=0, pointers=0, FSM=IDLE.
- FSM states: IDLE (nothing in flight), WAIT (one request in flight), DROP (in-flight response to be discarded).
  - IDLE: mem_req = !halt && !redirect && (count < DEPTH). Accepted (mem_req&mem_gnt) -> WAIT, fetch_pc += 4.
  - WAIT: mem_rvalid writes {fetch PC, mem_rdata} to tail -> IDLE. redirect (with or without same-cycle rvalid) -> DROP if rvalid absent, IDLE if present (word discarded).
  - DROP: mem_rvalid discarded -> IDLE. No request issued in DROP.
- At most one outstanding request; no request issued in WAIT/DROP.
- Slot reservation: request issued only if count < DEPTH, evaluated on registered count (a same-cycle pop does not free a slot early).
- Pop: out_valid && out_ready && !redirect -> head advances.
- Redirect: count=0, pointers=0, fetch_pc=redirect_pc with [1:0]=0, out_valid=0 next cycle; same-cycle pop/push ignored. Redirect overrides halt.
- fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Each entry stores the PC it was fetched from; PC of WAIT request held in a register.
- halt mid-WAIT: response still enqueued; no further requests until halt=0.
- mem_gnt=0 while mem_req=1: request retried each cycle, mem_addr stable.

## Timing
- Request accepted cycle N; rvalid at N+1; entry written at end of N+1; out_valid=1 at N+2 (default build).
- Redirect in cycle N: mem_req may reassert at N+1 with mem_addr=redirect_pc; first redirected instruction at out_valid no earlier than N+3.
- Steady-state throughput: one instruction per two cycles (single outstanding).
- Full: count=DEPTH -> mem_req=0 until a pop is registered.
- Empty: out_valid=0, out_inst=NOP, out_pc=0.
- rst asserted mid-operation: all state to reset values immediately; in-flight response after rst deassert arrives in IDLE and is ignored.

## Configuration
- PREFETCH_BYPASS_EN defined: when queue empty, state WAIT, mem_rvalid=1 and no redirect, out_valid/out_inst/out_pc are driven combinationally from the response in the same cycle; if out_ready=1 the word is consumed and not written. Latency request->output = 1 cycle.
- Not defined: every word passes through the queue; output purely registered; latency 2 cycles.

## Structure
- defines.v: NOP encoding (32'h0000_0013), FSM state encodings (IDLE/WAIT/DROP, 2 bits).
- One sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty), instantiated at width 64 ({pc, inst}).
- FSM, fetch_pc and bypass mux in inst_prefetch_q.

## Test plan
- Reset release, mem_gnt=1 constant, memory returns addr-tagged words -> out_pc sequence 0,4,8,12 with matching out_inst; first out_valid two cycles after first accepted request.
- out_ready=0, DEPTH=4 -> exactly 4 requests issued then mem_req=0; out_ready=1 one cycle -> one pop, next request issued the cycle after.
- redirect with redirect_pc=32'h0000_0103 in WAIT with no rvalid -> DROP, late response discarded, next mem_addr=32'h0000_0100, queue empty.
- redirect same cycle as mem_rvalid and out_ready=1 -> word not enqueued, no pop, out_valid=0 next cycle.
- mem_gnt=0 for 3 cycles -> mem_req held, mem_addr stable; halt=1 in WAIT -> response enqueued, no further requests.
- fetch_pc redirected to 32'hFFFF_FFF8 -> fetched PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; with PREFETCH_BYPASS_EN, empty queue -> out_valid in same cycle as mem_rvalid.

Source files
------------

// File: rtl/inst_prefetch_q_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package inst_prefetch_q_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } pf_state_e;

    // One buffered fetch: the word and the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Clear the byte-offset bits of an address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_prefetch_q_if.sv
// Memory-port, pipeline-control and IF/ID output signals of the prefetch queue.
// master: the prefetch queue; slave: memory arbiter plus pipeline.
interface inst_prefetch_q_if;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        input  redirect, redirect_pc, halt,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  out_ready,
        output mem_req, mem_addr,
        output out_valid, out_inst, out_pc
    );

    modport slave (
        output redirect, redirect_pc, halt,
        output mem_gnt, mem_rvalid, mem_rdata,
        output out_ready,
        input  mem_req, mem_addr,
        input  out_valid, out_inst, out_pc
    );

endinterface

// File: rtl/inst_prefetch_q_sync_fifo.sv
// Synchronous FIFO with flush; push to a full or pop from an empty FIFO is ignored.
module inst_prefetch_q_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
        end
    end

    // Entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/inst_prefetch_q.sv
// Instruction prefetch queue: single-outstanding sequential fetcher feeding IF/ID.
// Build option: PREFETCH_BYPASS_EN lets a response reach the output in its
// arrival cycle when the queue is empty.
module inst_prefetch_q
    import inst_prefetch_q_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    inst_prefetch_q_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    pf_state_e    state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         issue_c;
    logic         rsp_take_c;
    logic         bypass_c;
    logic         push_c;
    logic         pop_c;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_raw;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;

    // Next-state, fetch address and response-acceptance decisions
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        issue_c    = 1'b0;
        rsp_take_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // slot check uses the registered count, so a same-cycle pop does not count
                issue_c = !bus.halt && !bus.redirect && (fifo_count < CNT_W'(DEPTH));
                if (issue_c && bus.mem_gnt) begin
                    state_d    = ST_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            ST_WAIT: begin
                if (bus.redirect) begin
                    state_d = bus.mem_rvalid ? ST_IDLE : ST_DROP;
                end else if (bus.mem_rvalid) begin
                    state_d    = ST_IDLE;
                    rsp_take_c = 1'b1;
                end
            end
            ST_DROP: begin
                if (bus.mem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.redirect) fetch_pc_d = word_align(bus.redirect_pc);
    end

    // State, fetch PC and in-flight request PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

`ifdef PREFETCH_BYPASS_EN
    assign bypass_c = fifo_empty && rsp_take_c;
`else
    assign bypass_c = 1'b0;
`endif

    assign push_c     = rsp_take_c && !(bypass_c && bus.out_ready);
    assign pop_c      = !fifo_empty && bus.out_ready && !bus.redirect;
    assign push_entry = '{pc: req_pc_q, inst: bus.mem_rdata};
    assign head       = fetch_entry_t'(head_raw);

    inst_prefetch_q_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .head_data (head_raw),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Memory request is held low while reset is asserted
    assign bus.mem_req  = issue_c && !rst;
    assign bus.mem_addr = fetch_pc_q;

    // Output head: bypassed response, queue head, or NOP/0 when empty
    assign bus.out_valid = bypass_c || !fifo_empty;
    assign bus.out_inst  = bypass_c ? bus.mem_rdata : (fifo_empty ? NOP_INST : head.inst);
    assign bus.out_pc    = bypass_c ? req_pc_q    : (fifo_empty ? 32'h0    : head.pc);

endmodule

// File: tb/tb_inst_prefetch_q.sv
// Directed testbench for inst_prefetch_q (DEPTH=4, RESET_PC=0).
module tb_inst_prefetch_q;
    import inst_prefetch_q_pkg::*;

`ifdef PREFETCH_BYPASS_EN
    localparam int   LAT = 1;
    localparam logic BYP = 1'b1;
`else
    localparam int   LAT = 2;
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_prefetch_q_if bus();

    inst_prefetch_q #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_acc   = 0;
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    // Memory model state: one response pending, normally 1 cycle, 2 when late
    logic        resp_pend = 1'b0;
    int          resp_wait = 0;
    logic [31:0] resp_addr = 32'h0;
    logic        late      = 1'b0;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {16'hDEAD, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Log accepted requests and pops, then cross the edge and drive the response
    task automatic advance();
        if (bus.mem_req && bus.mem_gnt) begin
            n_acc++;
            acc_q.push_back(bus.mem_addr);
            resp_pend = 1'b1;
            resp_wait = late ? 2 : 1;
            resp_addr = bus.mem_addr;
        end
        if (bus.out_valid && bus.out_ready && !bus.redirect) begin
            pop_pc.push_back(bus.out_pc);
            pop_inst.push_back(bus.out_inst);
        end
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        if (resp_pend) begin
            resp_wait--;
            if (resp_wait == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = tag(resp_addr);
                resp_pend      = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.halt = 1'b0;
        bus.mem_gnt = 1'b0; bus.out_ready = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        resp_pend = 1'b0; late = 1'b0;
        cyc();
        cyc();
        acc_q.delete(); pop_pc.delete(); pop_inst.delete();
        n_acc = 0;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc[4];
        logic [31:0] exp_inst[4];
        logic [31:0] wrap_pc[3];
        logic [31:0] wrap_inst[3];
        int first_acc;
        int first_val;

        exp_pc    = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_inst  = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008, 32'hDEAD_000C};
        wrap_pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        wrap_inst = '{32'hDEAD_FFF8, 32'hDEAD_FFFC, 32'hDEAD_0000};

        // Reset values
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.halt = 1'b0;
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        settle();
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_inst",  bus.out_inst, 32'h0000_0013);
        check("rst_out_pc",    bus.out_pc, 32'h0);
        advance();

        // Sequential stream with constant grant and ready
        do_reset();
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b1;
        first_acc = -1; first_val = -1;
        for (int i = 0; i < 12; i++) begin
            settle();
            if (i == 0) begin
                check("seq_first_req",  32'(bus.mem_req), 32'd1);
                check("seq_first_addr", bus.mem_addr, 32'h0);
                check("seq_empty_inst", bus.out_inst, 32'h0000_0013);
                check("seq_empty_pc",   bus.out_pc, 32'h0);
            end
            if (first_acc < 0 && bus.mem_req && bus.mem_gnt) first_acc = i;
            if (first_val < 0 && bus.out_valid) first_val = i;
            advance();
        end
        check("seq_latency", 32'(first_val - first_acc), 32'(LAT));
        check("seq_pop_cnt", 32'(pop_pc.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("seq_pc",   pop_pc[k],   exp_pc[k]);
            check("seq_inst", pop_inst[k], exp_inst[k]);
        end

        // Fill to DEPTH with out_ready low, then a single pop
        do_reset();
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b0;
        repeat (14) cyc();
        bus.out_ready = 1'b1;
        settle();
        check("full_req",      32'(bus.mem_req), 32'd0);
        check("full_acc",      32'(n_acc), 32'd4);
        check("full_valid",    32'(bus.out_valid), 32'd1);
        check("full_head_pc",  bus.out_pc, 32'h0);
        advance();
        bus.out_ready = 1'b0;
        settle();
        check("refill_req",     32'(bus.mem_req), 32'd1);
        check("refill_addr",    bus.mem_addr, 32'h10);
        check("refill_head_pc", bus.out_pc, 32'h4);
        advance();
        cyc();
        settle();
        check("refull_req", 32'(bus.mem_req), 32'd0);
        check("refull_acc", 32'(n_acc), 32'd5);
        advance();

        // Redirect in WAIT without response; late response dropped
        do_reset();
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b0; late = 1'b1;
        cyc();
        late = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
        settle();
        check("wait_no_req", 32'(bus.mem_req), 32'd0);
        advance();
        bus.redirect = 1'b0;
        settle();
        check("drop_no_req", 32'(bus.mem_req), 32'd0);
        check("drop_empty",  32'(bus.out_valid), 32'd0);
        advance();
        settle();
        check("redir_req",   32'(bus.mem_req), 32'd1);
        check("redir_addr",  bus.mem_addr, 32'h0000_0100);
        check("redir_empty", 32'(bus.out_valid), 32'd0);
        advance();
        cyc();
        settle();
        check("redir_valid",   32'(bus.out_valid), 32'd1);
        check("redir_head_pc", bus.out_pc, 32'h0000_0100);
        check("redir_head_in", bus.out_inst, 32'hDEAD_0100);
        advance();

        // Redirect together with rvalid and out_ready
        do_reset();
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b0;
        repeat (3) cyc();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200; bus.out_ready = 1'b1;
        settle();
        check("rr_head_valid", 32'(bus.out_valid), 32'd1);
        check("rr_head_pc",    bus.out_pc, 32'h0);
        advance();
        bus.redirect = 1'b0; bus.out_ready = 1'b0; bus.mem_gnt = 1'b0;
        settle();
        check("rr_valid", 32'(bus.out_valid), 32'd0);
        check("rr_inst",  bus.out_inst, 32'h0000_0013);
        check("rr_pc",    bus.out_pc, 32'h0);
        check("rr_req",   32'(bus.mem_req), 32'd1);
        check("rr_addr",  bus.mem_addr, 32'h0000_0200);
        advance();

        // Grant stall for three cycles, then halt while in WAIT
        for (int i = 0; i < 2; i++) begin
            settle();
            check("stall_req",  32'(bus.mem_req), 32'd1);
            check("stall_addr", bus.mem_addr, 32'h0000_0200);
            advance();
        end
        bus.mem_gnt = 1'b1;
        settle();
        check("stall_go_addr", bus.mem_addr, 32'h0000_0200);
        advance();
        bus.halt = 1'b1;
        settle();
        check("halt_wait_req", 32'(bus.mem_req), 32'd0);
        advance();
        settle();
        check("halt_req",     32'(bus.mem_req), 32'd0);
        check("halt_valid",   32'(bus.out_valid), 32'd1);
        check("halt_head_pc", bus.out_pc, 32'h0000_0200);
        check("halt_head_in", bus.out_inst, 32'hDEAD_0200);
        advance();
        settle();
        check("halt_hold_req", 32'(bus.mem_req), 32'd0);
        check("halt_acc",      32'(n_acc), 32'd3);
        advance();
        bus.halt = 1'b0;
        settle();
        check("unhalt_req",  32'(bus.mem_req), 32'd1);
        check("unhalt_addr", bus.mem_addr, 32'h0000_0204);
        advance();

        // Address wrap past 32'hFFFF_FFFC
        do_reset();
        bus.mem_gnt = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
        settle();
        check("redir_blocks_req", 32'(bus.mem_req), 32'd0);
        advance();
        bus.redirect = 1'b0; bus.out_ready = 1'b1;
        repeat (8) cyc();
        for (int k = 0; k < 3; k++) begin
            check("wrap_req_addr", acc_q[k],    wrap_pc[k]);
            check("wrap_pop_pc",   pop_pc[k],   wrap_pc[k]);
            check("wrap_pop_inst", pop_inst[k], wrap_inst[k]);
        end

        // Empty queue: response visible in its own cycle only with bypass
        do_reset();
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b1;
        cyc();
        settle();
        check("byp_valid", 32'(bus.out_valid), 32'(BYP));
        check("byp_inst",  bus.out_inst, BYP ? 32'hDEAD_0000 : 32'h0000_0013);
        advance();
        bus.mem_gnt = 1'b0;
        settle();
        check("byp_after_valid", 32'(bus.out_valid), BYP ? 32'd0 : 32'd1);
        advance();

        // Reset mid-operation with a response still in flight
        do_reset();
        bus.mem_gnt = 1'b1; bus.out_ready = 1'b0;
        repeat (4) cyc();
        late = 1'b1;
        cyc();
        late = 1'b0;
        rst = 1'b1;
        settle();
        check("mid_rst_req",   32'(bus.mem_req), 32'd0);
        check("mid_rst_addr",  bus.mem_addr, 32'h0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_inst",  bus.out_inst, 32'h0000_0013);
        check("mid_rst_pc",    bus.out_pc, 32'h0);
        advance();
        rst = 1'b0; bus.mem_gnt = 1'b0;
        cyc();
        settle();
        check("stale_ignored", 32'(bus.out_valid), 32'd0);
        check("stale_req",     32'(bus.mem_req), 32'd1);
        check("stale_addr",    bus.mem_addr, 32'h0);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
